rq_arbiter: RTL and testbench
=============================

# rq_arbiter

Round-robin arbiter merging four independent 32-bit data-request streams into the single request stream consumed by the request manager's RQ input. It enforces a limit on requests that have been issued but whose output packets have not yet completed, and can tag each request with its source index. It sits between the host-side requesters and the request manager, and completion is signalled back by a one-cycle `pkt_done` pulse per finished packet.

## Interface
- `NUM_SRC`, 4: number of request sources. Fixed at 4 in this revision.
- `MAX_OUTSTANDING`, 2: maximum issued-but-uncompleted requests. Legal range 1–15.
- `TAG_SOURCE`, 1: when 1, output TDATA[31:30] is replaced by the granted source index.
- `clk`  in  1  clock; the only clock.
- `resetn`  in  1  synchronous, active-low reset.
- `AXIS_IN_TDATA`  in  128  packed requests; source k occupies bits [32k+31:32k].
- `AXIS_IN_TVALID`  in  4  per-source valid.
- `AXIS_IN_TREADY`  out  4  per-source ready; combinational, at most one bit high.
- `AXIS_RQ_TDATA`  out  32  registered arbitrated request.
- `AXIS_RQ_TVALID`  out  1  registered valid.
- `AXIS_RQ_TREADY`  in  1  ready from the request manager.
- `pkt_done`  in  1  one-cycle pulse per packet fully transmitted, i.e. footer accepted.
- `outstanding`  out  4  current count of issued, uncompleted requests.
- `underflow_err`  out  1  sticky; set by `pkt_done` while `outstanding` == 0.

## Operation
- **Output register.** The output register holds a single request.
  - `slot_free` = !AXIS_RQ_TVALID | AXIS_RQ_TREADY.
  - `credit_ok` = (outstanding + AXIS_RQ_TVALID) < MAX_OUTSTANDING.
  - A `pkt_done` pulse in the same cycle does not count toward `credit_ok`. This is conservative and takes effect the next cycle.
- **Grant.** When `slot_free & credit_ok`, the grant goes to the first source with TVALID=1, scanning from (last_grant+1) mod 4 upward and wrapping.
  - Only that source's AXIS_IN_TREADY is driven high. Otherwise all ready bits are 0.
  - AXIS_IN_TREADY may depend on AXIS_IN_TVALID and AXIS_RQ_TREADY, never the reverse.
- **Load.** On an input handshake, the output register loads TDATA and sets TVALID=1, and `last_grant` updates to the granted index.
  - With TAG_SOURCE=1, TDATA = {idx[1:0], in[29:0]}.
  - With TAG_SOURCE=0, TDATA = in[31:0].
- **Drain.** On an output handshake with no new input handshake, TVALID goes to 0. TDATA holds its value.
- **Counter.** `outstanding` increments by 1 on each output handshake and decrements by 1 on each `pkt_done`.
  - Both in the same cycle: the count is unchanged.
  - `pkt_done` with `outstanding` == 0: the count stays 0 and `underflow_err` is set to 1. It is cleared only by reset.
- **Stability.** While AXIS_RQ_TVALID=1 and AXIS_RQ_TREADY=0, TDATA and TVALID hold stable, per AXIS rules.

## Timing
- **Reset values.** AXIS_RQ_TVALID=0, AXIS_RQ_TDATA=0, AXIS_IN_TREADY=0, outstanding=0, underflow_err=0, last_grant=3, so the first grant scans from source 0.
- **Latency.** An input handshake in cycle N puts the request on the output (TVALID=1) in cycle N+1.
- **Throughput.** One request per cycle when AXIS_RQ_TREADY is held high and credit allows. Output handshake and input handshake can occur in the same cycle.
- **Credit limit.** With MAX_OUTSTANDING=2, the third request is not granted until a `pkt_done` is seen. The grant is possible in the cycle after the pulse.
- **Reset mid-operation.** A buffered request is discarded and the counter is cleared. Sources must re-present requests.
- **Fairness.** A continuously-valid source is granted at least once every 4 grants.

## Test plan
- **Single source.** After reset, source 2 presents 0x0000_1234 with AXIS_RQ_TREADY=1 -> AXIS_IN_TREADY=4'b0100 in the same cycle. Next cycle AXIS_RQ_TDATA=0x8000_1234 (tag 2) and TVALID=1. Then `outstanding`=1.
- **Round robin.** All 4 sources valid continuously, MAX_OUTSTANDING=15, AXIS_RQ_TREADY=1, `pkt_done` pulsed every cycle -> grant order 0,1,2,3,0,1. One output per cycle after the first.
- **Credit limit.** MAX_OUTSTANDING=2, source 0 always valid, no `pkt_done` -> exactly 2 output handshakes, then AXIS_IN_TREADY stays 0. Pulse `pkt_done` once -> one more request is issued, and `outstanding` returns to 2.
- **Backpressure.** AXIS_RQ_TREADY=0 for 10 cycles with a request loaded -> TDATA and TVALID stable, and AXIS_IN_TREADY=0. Release -> the handshake occurs, and a new grant happens in the same cycle.
- **Simultaneous and underflow.** An output handshake coincident with `pkt_done` at `outstanding`=1 -> `outstanding` stays 1. `pkt_done` at 0 -> `underflow_err`=1, and it stays 1 until resetn=0.
- **Reset mid-stream.** Assert resetn=0 for 1 cycle while TVALID=1 and `outstanding`=2 -> all outputs at their reset values the next cycle. The next grant is to source 0.

Source files
------------

// File: rtl/rq_arbiter.sv
// rq_arbiter: round-robin merge of four 32-bit request streams into one
// registered request stream. Limits how many requests may be issued but not
// yet completed, and can tag each request with its source index.
module rq_arbiter #(
    parameter int unsigned NUM_SRC         = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned TAG_SOURCE      = 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_SRC*32-1:0]     AXIS_IN_TDATA,
    input  logic [NUM_SRC-1:0]        AXIS_IN_TVALID,
    output logic [NUM_SRC-1:0]        AXIS_IN_TREADY,
    output logic [31:0]               AXIS_RQ_TDATA,
    output logic                      AXIS_RQ_TVALID,
    input  logic                      AXIS_RQ_TREADY,
    input  logic                      pkt_done,
    output logic [3:0]                outstanding,
    output logic                      underflow_err
);

    localparam int unsigned DW   = 32;
    localparam int unsigned IDXW = 2;
    localparam int unsigned CNTW = 4;

    logic [DW-1:0]   rq_tdata_q, rq_tdata_d;
    logic            rq_tvalid_q, rq_tvalid_d;
    logic [IDXW-1:0] last_grant_q, last_grant_d;
    logic [CNTW-1:0] outstanding_q, outstanding_d;
    logic            underflow_q, underflow_d;

    logic            grant_vld;
    logic [IDXW-1:0] grant_idx;
    logic            slot_free;
    logic            credit_ok;
    logic            in_hs;
    logic            out_hs;
    logic [CNTW:0]   inflight;

    // Round-robin search starting one past the last granted source
    always_comb begin
        logic [IDXW-1:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned off = 1; off <= NUM_SRC; off++) begin
            cand = last_grant_q + IDXW'(off);
            if (!grant_vld && AXIS_IN_TVALID[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Grant qualification: free output slot and credit; a same-cycle
    // pkt_done is deliberately not counted back as credit
    always_comb begin
        inflight       = {1'b0, outstanding_q} + (CNTW+1)'(rq_tvalid_q);
        slot_free      = !rq_tvalid_q || AXIS_RQ_TREADY;
        credit_ok      = inflight < (CNTW+1)'(MAX_OUTSTANDING);
        in_hs          = resetn && slot_free && credit_ok && grant_vld;
        out_hs         = rq_tvalid_q && AXIS_RQ_TREADY;
        AXIS_IN_TREADY = in_hs ? (NUM_SRC'(1) << grant_idx) : '0;
    end

    // Next-state for output register, grant pointer and credit counter
    always_comb begin
        rq_tdata_d    = rq_tdata_q;
        rq_tvalid_d   = rq_tvalid_q;
        last_grant_d  = last_grant_q;
        outstanding_d = outstanding_q;
        underflow_d   = underflow_q;

        if (in_hs) begin
            rq_tdata_d   = AXIS_IN_TDATA[grant_idx*DW +: DW];
            if (TAG_SOURCE != 0) begin
                rq_tdata_d[DW-1:DW-IDXW] = grant_idx;
            end
            rq_tvalid_d  = 1'b1;
            last_grant_d = grant_idx;
        end else if (out_hs) begin
            rq_tvalid_d  = 1'b0;
        end

        if (pkt_done && (outstanding_q == '0)) begin
            underflow_d = 1'b1;
            if (out_hs) begin
                outstanding_d = outstanding_q + CNTW'(1);
            end
        end else if (out_hs && !pkt_done) begin
            outstanding_d = outstanding_q + CNTW'(1);
        end else if (!out_hs && pkt_done) begin
            outstanding_d = outstanding_q - CNTW'(1);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rq_tdata_q    <= '0;
            rq_tvalid_q   <= 1'b0;
            last_grant_q  <= IDXW'(NUM_SRC - 1);
            outstanding_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            rq_tdata_q    <= rq_tdata_d;
            rq_tvalid_q   <= rq_tvalid_d;
            last_grant_q  <= last_grant_d;
            outstanding_q <= outstanding_d;
            underflow_q   <= underflow_d;
        end
    end

    assign AXIS_RQ_TDATA  = rq_tdata_q;
    assign AXIS_RQ_TVALID = rq_tvalid_q;
    assign outstanding    = outstanding_q;
    assign underflow_err  = underflow_q;

endmodule

// File: tb/tb_rq_arbiter.sv
// Directed bench for rq_arbiter: one instance with a credit limit of 2,
// a second with a limit of 15 for the round-robin sequence.
module tb_rq_arbiter;

    logic         clk;
    logic         resetn;

    logic [127:0] in_tdata;
    logic [3:0]   in_tvalid;
    logic [3:0]   in_tready;
    logic [31:0]  rq_tdata;
    logic         rq_tvalid;
    logic         rq_tready;
    logic         pkt_done;
    logic [3:0]   outstanding;
    logic         uerr;

    logic [127:0] in15_tdata;
    logic [3:0]   in15_tvalid;
    logic [3:0]   in15_tready;
    logic [31:0]  rq15_tdata;
    logic         rq15_tvalid;
    logic         rq15_tready;
    logic         pkt15;
    logic [3:0]   out15;
    logic         uerr15;

    int n_tests;
    int n_fail;

    rq_arbiter #(.NUM_SRC(4), .MAX_OUTSTANDING(2), .TAG_SOURCE(1)) dut (
        .clk(clk), .resetn(resetn),
        .AXIS_IN_TDATA(in_tdata), .AXIS_IN_TVALID(in_tvalid), .AXIS_IN_TREADY(in_tready),
        .AXIS_RQ_TDATA(rq_tdata), .AXIS_RQ_TVALID(rq_tvalid), .AXIS_RQ_TREADY(rq_tready),
        .pkt_done(pkt_done), .outstanding(outstanding), .underflow_err(uerr)
    );

    rq_arbiter #(.NUM_SRC(4), .MAX_OUTSTANDING(15), .TAG_SOURCE(1)) dut15 (
        .clk(clk), .resetn(resetn),
        .AXIS_IN_TDATA(in15_tdata), .AXIS_IN_TVALID(in15_tvalid), .AXIS_IN_TREADY(in15_tready),
        .AXIS_RQ_TDATA(rq15_tdata), .AXIS_RQ_TVALID(rq15_tvalid), .AXIS_RQ_TREADY(rq15_tready),
        .pkt_done(pkt15), .outstanding(out15), .underflow_err(uerr15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then driven 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        resetn      = 1'b0;
        in_tdata    = '0;
        in_tvalid   = '0;
        rq_tready   = 1'b0;
        pkt_done    = 1'b0;
        in15_tdata  = '0;
        in15_tvalid = '0;
        rq15_tready = 1'b0;
        pkt15       = 1'b0;
        step();
        step();
        check("rst_tvalid", 32'(rq_tvalid), 32'd0);
        check("rst_tdata", rq_tdata, 32'd0);
        check("rst_outstanding", 32'(outstanding), 32'd0);
        check("rst_uerr", 32'(uerr), 32'd0);
        check("rst_tready", 32'(in_tready), 32'd0);
        resetn = 1'b1;
        step();

        // Round robin on the deep-credit instance
        for (int k = 0; k < 4; k++) in15_tdata[k*32 +: 32] = 32'h0000_00A0 + 32'(k);
        in15_tvalid = 4'b1111;
        rq15_tready = 1'b1;
        pkt15       = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] exp_d;
            #1;
            check("rr_ready", 32'(in15_tready), 32'(4'b0001 << (i % 4)));
            step();
            exp_d        = 32'h0000_00A0 + 32'(i % 4);
            exp_d[31:30] = 2'(i % 4);
            check("rr_tdata", rq15_tdata, exp_d);
            check("rr_tvalid", 32'(rq15_tvalid), 32'd1);
        end
        in15_tvalid = '0;
        pkt15       = 1'b0;

        // Single source: source 2, tag 2 in the top bits
        in_tdata[95:64] = 32'h0000_1234;
        in_tvalid       = 4'b0100;
        rq_tready       = 1'b1;
        #1;
        check("single_ready", 32'(in_tready), 32'b0100);
        step();
        in_tvalid = '0;
        check("single_tdata", rq_tdata, 32'h8000_1234);
        check("single_tvalid", 32'(rq_tvalid), 32'd1);
        step();
        check("single_outstanding", 32'(outstanding), 32'd1);
        check("single_drain", 32'(rq_tvalid), 32'd0);
        pkt_done = 1'b1;
        step();
        pkt_done = 1'b0;
        check("single_done", 32'(outstanding), 32'd0);

        // Credit limit with source 0 always valid
        in_tdata[31:0] = 32'h0000_0011;
        in_tvalid      = 4'b0001;
        #1;
        check("credit_g1", 32'(in_tready), 32'b0001);
        step();
        #1;
        check("credit_g2", 32'(in_tready), 32'b0001);
        step();
        #1;
        check("credit_block1", 32'(in_tready), 32'd0);
        step();
        check("credit_out2", 32'(outstanding), 32'd2);
        check("credit_tvalid0", 32'(rq_tvalid), 32'd0);
        step();
        step();
        check("credit_block2", 32'(in_tready), 32'd0);
        check("credit_hold", 32'(outstanding), 32'd2);
        pkt_done = 1'b1;
        #1;
        check("credit_same_cycle", 32'(in_tready), 32'd0);
        step();
        pkt_done = 1'b0;
        check("credit_dec", 32'(outstanding), 32'd1);
        #1;
        check("credit_regrant", 32'(in_tready), 32'b0001);
        step();
        #1;
        check("credit_block3", 32'(in_tready), 32'd0);
        step();
        check("credit_back2", 32'(outstanding), 32'd2);
        in_tvalid = '0;

        // Simultaneous output handshake and pkt_done, then underflow
        pkt_done = 1'b1;
        step();
        pkt_done = 1'b0;
        check("sim_pre", 32'(outstanding), 32'd1);
        in_tdata[63:32] = 32'h0000_0055;
        in_tvalid       = 4'b0010;
        #1;
        check("sim_ready", 32'(in_tready), 32'b0010);
        step();
        in_tvalid = '0;
        check("sim_tdata", rq_tdata, 32'h4000_0055);
        pkt_done = 1'b1;
        step();
        pkt_done = 1'b0;
        check("sim_outstanding", 32'(outstanding), 32'd1);
        check("sim_tdata_hold", rq_tdata, 32'h4000_0055);
        pkt_done = 1'b1;
        step();
        check("uf_zero", 32'(outstanding), 32'd0);
        check("uf_not_yet", 32'(uerr), 32'd0);
        step();
        pkt_done = 1'b0;
        check("uf_set", 32'(uerr), 32'd1);
        check("uf_count", 32'(outstanding), 32'd0);
        step();
        step();
        check("uf_sticky", 32'(uerr), 32'd1);

        // Backpressure: source 3 loaded, output stalled 10 cycles
        rq_tready        = 1'b0;
        in_tdata[127:96] = 32'h0000_0777;
        in_tvalid        = 4'b1000;
        #1;
        check("bp_ready", 32'(in_tready), 32'b1000);
        step();
        in_tvalid      = 4'b1001;
        in_tdata[31:0] = 32'h0000_0999;
        for (int i = 0; i < 10; i++) begin
            check("bp_tdata", rq_tdata, 32'hC000_0777);
            check("bp_tvalid", 32'(rq_tvalid), 32'd1);
            check("bp_noready", 32'(in_tready), 32'd0);
            step();
        end
        rq_tready = 1'b1;
        #1;
        check("bp_release_grant", 32'(in_tready), 32'b0001);
        step();
        in_tvalid = '0;
        check("bp_new_tdata", rq_tdata, 32'h0000_0999);
        check("bp_new_tvalid", 32'(rq_tvalid), 32'd1);
        check("bp_outstanding", 32'(outstanding), 32'd1);

        // Reset mid-stream with a request buffered
        in_tvalid = 4'b1111;
        rq_tready = 1'b0;
        resetn    = 1'b0;
        #1;
        check("mid_rst_ready", 32'(in_tready), 32'd0);
        step();
        check("mid_rst_tvalid", 32'(rq_tvalid), 32'd0);
        check("mid_rst_tdata", rq_tdata, 32'd0);
        check("mid_rst_outstanding", 32'(outstanding), 32'd0);
        check("mid_rst_uerr", 32'(uerr), 32'd0);
        resetn = 1'b1;
        #1;
        check("mid_rst_first_grant", 32'(in_tready), 32'b0001);
        step();
        in_tvalid = '0;
        check("mid_rst_tdata_after", rq_tdata, 32'h0000_0999);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
